// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encodings, bus mode constants and divider limit.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_TRAIL = 3'd4,
        ST_GAP   = 3'd5
    } spi_state_e;

    // Mode 0: sclk idles low, data sampled on the rising half (HIGH phase).
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    localparam int unsigned SCLK_DIV_MIN = 2;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period tick generator: counts DIV enabled cycles and flags the last one.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    // Dividers below the minimum are clamped so the counter never degenerates.
    localparam int unsigned DIV_EFF = (DIV < SCLK_DIV_MIN) ? SCLK_DIV_MIN : DIV;
    localparam int unsigned CNT_W   = $clog2(DIV_EFF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_EFF - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = enable && (cnt_q == CNT_LAST);

    // Counter restarts on every tick (state change) and while disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_driver.sv
// SPI master, mode 0, MSB first, with registered outputs and a fixed lead/trail/gap framing.
module spi_master_driver
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SCLK_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs
);

    localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
    localparam logic SAMPLE_IN_HIGH = (CPHA == 1'b0);

    spi_state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  mosi_q, mosi_d;
    logic                  done_q, done_d;
    logic                  ready_q, ready_d;
    logic                  cs_q, cs_d;
    logic                  sclk_q, sclk_d;
    logic                  tick;

    spi_sclk_gen #(
        .DIV (SCLK_DIV)
    ) u_sclk_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (state_q != ST_IDLE),
        .tick   (tick)
    );

    // Next-state, datapath and output decode; outputs follow the state being entered.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        bit_d      = bit_q;
        mosi_d     = mosi_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tx_d    = data_in;
                    rx_d    = '0;
                    bit_d   = '0;
                    mosi_d  = data_in[DATA_WIDTH-1];
                    state_d = ST_LEAD;
                end
            end
            ST_LEAD: begin
                if (tick) begin
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    if (SAMPLE_IN_HIGH) begin
                        rx_d = {rx_q[DATA_WIDTH-2:0], miso};
                    end
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_TRAIL;
                    end else begin
                        tx_d    = {tx_q[DATA_WIDTH-2:0], 1'b0};
                        mosi_d  = tx_q[DATA_WIDTH-2];
                        bit_d   = bit_q + BIT_W'(1);
                        state_d = ST_HIGH;
                    end
                end
            end
            ST_TRAIL: begin
                if (tick) begin
                    done_d     = 1'b1;
                    data_out_d = rx_q;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        cs_d    = !((state_d == ST_LEAD) || (state_d == ST_HIGH) ||
                    (state_d == ST_LOW)  || (state_d == ST_TRAIL));
        sclk_d  = (state_d == ST_HIGH) ^ CPOL;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            bit_q      <= '0;
            mosi_q     <= 1'b0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
            cs_q       <= 1'b1;
            sclk_q     <= CPOL;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            bit_q      <= bit_d;
            mosi_q     <= mosi_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign data_out = data_out_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs       = cs_q;

endmodule
